// File: rtl/ula_pkg.sv
// ula_pkg: shared FSM state encodings and add/sub mode constants for the ALU datapath
package ula_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_FIM = 2'd2} estado_t;
  localparam logic MODO_SOMA = 1'b0;
  localparam logic MODO_SUB  = 1'b1;
endpackage

// File: rtl/somador_digito.sv
// somador_digito: combinational DIGIT-bit adder; ports a, b, cin in, s, cout out
module somador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial: digit-serial add/sub; in clk rst start modo a b, out busy done s cout overflow zero
module somador_subtrator_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  estado_t st, st_n;
  logic [WIDTH-1:0] op_a, op_b, acc, res;
  logic [DIGIT-1:0] dsum;
  logic [CW-1:0] cnt;
  logic carry, dco, accept, last;
  somador_digito #(.DIGIT(DIGIT)) u_dig (
    .a   (op_a[cnt*DIGIT +: DIGIT]),
    .b   (op_b[cnt*DIGIT +: DIGIT]),
    .cin (carry),
    .s   (dsum),
    .cout(dco)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= ST_IDLE;
    else st <= st_n;
  always_comb begin
    last   = cnt == LAST;
    accept = start && st != ST_CALC;
    busy   = st == ST_CALC;
    done   = st == ST_FIM;
    st_n   = st == ST_CALC ? (last ? ST_FIM : ST_CALC) : (accept ? ST_CALC : ST_IDLE);
  end
  always_comb begin
    res = acc;
    res[cnt*DIGIT +: DIGIT] = dsum;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{modo}};
      carry <= modo;
      cnt   <= '0;
    end else if (st == ST_CALC) begin
      acc   <= res;
      carry <= dco;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        s        <= res;
        cout     <= dco;
        overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
        zero     <= res == '0;
      end
    end
endmodule

// File: tb/tb_somador_subtrator_serial.sv
// tb_somador_subtrator_serial: scoreboard bench for N=4, N=16 and N=1 instances
module tb_somador_subtrator_serial;
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          cyc;
  } exp_t;
  logic clk, rst, modo;
  logic [2:0] start;
  logic [15:0] a, b;
  logic [2:0] busy, done, cout, ovf, zero;
  logic [15:0] s_o [3];
  exp_t q0[$], q1[$], q2[$];
  int nvec = 0, nerr = 0, cyc = 0;
  somador_subtrator_serial #(.WIDTH(16), .DIGIT(4)) d4 (
    .clk(clk), .rst(rst), .start(start[0]), .modo(modo), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .s(s_o[0]), .cout(cout[0]), .overflow(ovf[0]), .zero(zero[0])
  );
  somador_subtrator_serial #(.WIDTH(16), .DIGIT(1)) d1 (
    .clk(clk), .rst(rst), .start(start[1]), .modo(modo), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .s(s_o[1]), .cout(cout[1]), .overflow(ovf[1]), .zero(zero[1])
  );
  somador_subtrator_serial #(.WIDTH(16), .DIGIT(16)) d16 (
    .clk(clk), .rst(rst), .start(start[2]), .modo(modo), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .s(s_o[2]), .cout(cout[2]), .overflow(ovf[2]), .zero(zero[2])
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;
  function automatic int lat(int i);
    return i == 0 ? 4 : (i == 1 ? 16 : 1);
  endfunction
  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h expected %h at t=%0t", nm, i, got, want, $time);
    end
  endtask
  task automatic push(int i, exp_t e);
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic pop(int i, output exp_t e, output bit ok);
    ok = 0;
    if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
    if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
    if (i == 2 && q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
  endtask
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst)
        for (int i = 0; i < 3; i++)
          if (done[i]) begin
            pop(i, e, ok);
            if (!ok) chk("spurious_done", i, 32'd1, 32'd0);
            else begin
              chk("s", i, 32'(s_o[i]), 32'(e.s));
              chk("cout", i, 32'(cout[i]), 32'(e.c));
              chk("overflow", i, 32'(ovf[i]), 32'(e.v));
              chk("zero", i, 32'(zero[i]), 32'(e.z));
              chk("latency", i, 32'(cyc), 32'(e.cyc));
            end
          end
    end
  end
  task automatic issue(int i, logic m, logic [15:0] x, logic [15:0] y,
                       logic [15:0] es, logic ec, logic ev, logic ez);
    exp_t e;
    @(negedge clk);
    modo = m; a = x; b = y; start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    e.s = es; e.c = ec; e.v = ev; e.z = ez; e.cyc = cyc + lat(i);
    push(i, e);
  endtask
  task automatic wait_done(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 40);
    if (!done[i]) chk("done_timeout", i, 32'd0, 32'd1);
  endtask
  initial begin
    exp_t e;
    bit ok;
    rst = 1; start = '0; modo = 0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, 32'(busy[0]), 0);
    chk("rst_done", 0, 32'(done[0]), 0);
    chk("rst_s", 0, 32'(s_o[0]), 0);
    chk("rst_flags", 0, 32'({cout[0], ovf[0], zero[0]}), 0);
    rst = 0;
    issue(0, 1, 16'h1234, 16'h0234, 16'h1000, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_calc", 0, 32'(busy[0]), 1);
    end
    wait_done(0);
    issue(0, 1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0);
    wait_done(0);
    issue(0, 1, 16'hABCD, 16'hABCD, 16'h0000, 1, 0, 1);
    wait_done(0);
    issue(0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    wait_done(0);
    issue(0, 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0);
    wait_done(0);
    issue(0, 0, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0);
    @(negedge clk);
    start[0] = 1; modo = 1; a = 16'hDEAD; b = 16'hBEEF;
    @(negedge clk);
    start[0] = 0; a = 16'h5555;
    chk("hold_s", 0, 32'(s_o[0]), 32'h7FFF);
    wait_done(0);
    modo = 0; a = 16'hFFFF; b = 16'h0001; start[0] = 1;
    @(posedge clk);
    #1 start[0] = 0;
    e.s = 16'h0000; e.c = 1; e.v = 0; e.z = 1; e.cyc = cyc + 4;
    push(0, e);
    @(negedge clk);
    chk("busy_b2b", 0, 32'(busy[0]), 1);
    chk("hold_s_b2b", 0, 32'(s_o[0]), 32'h3333);
    wait_done(0);
    issue(0, 0, 16'h0F0F, 16'h0101, 16'h1010, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1;
    #1;
    pop(0, e, ok);
    chk("abort_pending", 0, 32'(ok), 1);
    chk("abort_busy", 0, 32'(busy[0]), 0);
    chk("abort_done", 0, 32'(done[0]), 0);
    chk("abort_s", 0, 32'(s_o[0]), 0);
    chk("abort_flags", 0, 32'({cout[0], ovf[0], zero[0]}), 0);
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    issue(0, 1, 16'h0010, 16'h0001, 16'h000F, 1, 0, 0);
    wait_done(0);
    issue(1, 1, 16'h1234, 16'h0234, 16'h1000, 1, 0, 0);
    wait_done(1);
    issue(2, 1, 16'h1234, 16'h0234, 16'h1000, 1, 0, 0);
    wait_done(2);
    issue(2, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    wait_done(2);
    repeat (3) @(negedge clk);
    chk("left_in_queues", 0, 32'(q0.size() + q1.size() + q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/somador_subtrator_serial.md
Name: somador_subtrator_serial

Overview:
- Multi-cycle, parametrised add/subtract unit for the ALU datapath.
- Processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first, with the carry held in a register between digits.
- Subtraction is computed as A + (~B) + 1.
- Uses a start/busy/done handshake and reports carry (not-borrow), signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; legal range 1..WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while busy=0.
- modo  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A (minuend); sampled with start.
- b  input  WIDTH  operand B (subtrahend); sampled with start.
- busy  output  1  high while digits are being computed.
- done  output  1  one-cycle pulse: result and flags are valid.
- s  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry; in subtraction 1 = no borrow (A>=B unsigned), 0 = borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset: while rst=1, the block asynchronously clears to state IDLE.
  - busy=0, done=0, s=0, cout=0, overflow=0, zero=0.
  - All internal operand, carry and counter registers are 0.
- N = WIDTH/DIGIT.
- States are IDLE, CALC and FIM.
  - IDLE: busy=0, done=0. If start=1, on that edge:
    - latch a;
    - latch b XOR {WIDTH{modo}};
    - carry <= modo;
    - digit counter <= 0;
    - go to CALC.
  - CALC: busy=1, done=0. Each edge:
    - the DIGIT-bit sum of the current operand digits plus carry is written into the corresponding digit of the result;
    - carry updates;
    - counter increments.
    - On the edge that processes digit N-1, go to FIM.
    - start is ignored throughout CALC.
  - FIM: busy=0, done=1 for exactly this one cycle.
    - If start=1, the new operation is accepted exactly as from IDLE (back-to-back) and the state goes to CALC.
    - Otherwise go to IDLE.
- Latency: done is high in the cycle that begins N rising edges after the accepting edge. Throughput is one operation per N+1 cycles.
- Outputs s, cout, overflow and zero:
  - update only on the edge entering FIM;
  - hold their values through IDLE and the next CALC until the next FIM;
  - are never partially updated or visible mid-computation.
- cout = carry out of bit WIDTH-1.
- overflow = (a[W-1] == b'[W-1]) and (s[W-1] != a[W-1]), where b' is the conditionally inverted B.
- zero is computed from the final s.
- Reset asserted mid-CALC:
  - the operation is abandoned;
  - outputs take reset values;
  - no done pulse is generated.
  - The first start after reset release behaves normally.
- modo, a and b changing during CALC have no effect.
- DIGIT=WIDTH (N=1) is legal: CALC lasts one cycle.
- DIGIT=1 is legal: bit-serial.

Decomposition:
- Shared package ula_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIM=2'd2;
  - mode constants MODO_SOMA=1'b0, MODO_SUB=1'b1, reused by the top-level ALU decode.
- One sub-module is natural: somador_digito.
  - Purely combinational, parametrised DIGIT-bit ripple adder.
  - Ports: a, b, cin, s, cout.
  - Instantiated once.
- The FSM, counter and shift/digit-select logic live in the top module.

Test Plan (WIDTH=16, DIGIT=4, N=4 unless stated):
1. modo=1, a=0x1234, b=0x0234, start pulse:
   - busy high for 4 cycles;
   - done high in the 4th cycle after the accepting edge;
   - s=0x1000, cout=1, overflow=0, zero=0.
2. modo=1, a=0x0003, b=0x0005 -> s=0xFFFE, cout=0 (borrow), overflow=0. Then modo=1, a=b=0xABCD -> s=0x0000, zero=1, cout=1.
3. modo=0, a=0x7FFF, b=0x0001 -> s=0x8000, overflow=1, cout=0. Then modo=1, a=0x8000, b=0x0001 -> s=0x7FFF, overflow=1, cout=1.
4. Inputs ignored while busy:
   - start pulsed and a/b/modo changed during CALC -> no restart, result unchanged from the originally latched operands;
   - start held high in the FIM cycle -> new operation accepted;
   - done of the second operation occurs N+1 cycles after the first done.
5. rst asserted asynchronously (between edges) in the 2nd CALC cycle:
   - busy, done, s and flags drop to 0 immediately;
   - no done pulse follows;
   - after release, a subtraction 0x0010-0x0001 gives s=0x000F, cout=1.
6. Parameter sweep DIGIT=1 (N=16) and DIGIT=16 (N=1) on 0x1234-0x0234 -> s=0x1000, cout=1, done exactly N cycles after acceptance.
